// File: rtl/branch_unit_pkg.sv
// Shared RV32I branch definitions: funct3 encodings of the conditional branches.
// Also consumed by the decoder and the control unit.
package branch_unit_pkg;

    localparam int unsigned FUNCT3_W = 3;

    localparam logic [FUNCT3_W-1:0] BEQ  = 3'b000;
    localparam logic [FUNCT3_W-1:0] BNE  = 3'b001;
    localparam logic [FUNCT3_W-1:0] BLT  = 3'b100;
    localparam logic [FUNCT3_W-1:0] BGE  = 3'b101;
    localparam logic [FUNCT3_W-1:0] BLTU = 3'b110;
    localparam logic [FUNCT3_W-1:0] BGEU = 3'b111;

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator for branch evaluation.
// A single XLEN+1-bit subtract produces the equal, signed-less-than and unsigned-less-than flags.
module branch_cmp #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    logic [XLEN:0] diff;

    // Zero-extended subtract: bit XLEN is the borrow, i.e. a < b unsigned
    assign diff = {1'b0, a} - {1'b0, b};

    assign eq  = (diff[XLEN-1:0] == '0);
    assign ltu = diff[XLEN];
    // Differing signs decide directly; same signs cannot overflow, so the difference sign is exact
    assign lt  = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch condition evaluator: combinational decision plus a registered
// copy that feeds the PC-redirect/flush logic one stage later.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned FUNCT3 = 3
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              En,
    input  logic [FUNCT3-1:0] funct3,
    input  logic [XLEN-1:0]   Rs1,
    input  logic [XLEN-1:0]   Rs2,
    output logic              Branch_taken,
    output logic              Branch_taken_r
);

    logic eq;
    logic lt;
    logic ltu;
    logic taken;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .a   (Rs1),
        .b   (Rs2),
        .eq  (eq),
        .lt  (lt),
        .ltu (ltu)
    );

    // Reserved and unknown encodings fall through to not-taken
    always_comb begin
        taken = 1'b0;
        if (En) begin
            case (funct3)
                BEQ:     taken = eq;
                BNE:     taken = ~eq;
                BLT:     taken = lt;
                BGE:     taken = ~lt;
                BLTU:    taken = ltu;
                BGEU:    taken = ~ltu;
                default: taken = 1'b0;
            endcase
        end
    end

    assign Branch_taken = taken;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Branch_taken_r <= 1'b0;
        end else begin
            Branch_taken_r <= taken;
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed and random vectors scored against a
// behavioural model through an expected-value queue.
module tb_branch_unit;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            branch_taken;
    logic            branch_taken_r;

    int   checks;
    int   passed;
    bit   exp_q[$];
    bit   cur_exp;
    event ev_apply;

    branch_unit #(
        .XLEN   (XLEN),
        .FUNCT3 (3)
    ) dut (
        .CLK            (clk),
        .rst_n          (rst_n),
        .En             (en),
        .funct3         (funct3),
        .Rs1            (rs1),
        .Rs2            (rs2),
        .Branch_taken   (branch_taken),
        .Branch_taken_r (branch_taken_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model(input bit e, input logic [2:0] f,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (!e) return 1'b0;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input bit got, input bit exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0b expected %0b (t=%0t f3=%0d rs1=%h rs2=%h en=%0b)",
                      name, got, exp, $time, funct3, rs1, rs2, en);
    endtask

    // Drive one vector at the falling edge and queue its expected decision
    task automatic apply(input bit e, input logic [2:0] f,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        en     = e;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        cur_exp = model(e, f, a, b);
        exp_q.push_back(cur_exp);
        -> ev_apply;
    endtask

    // Combinational monitor: one time unit after each input change
    always @(ev_apply) begin
        #1;
        if (exp_q.size() == 0) begin
            check("comb_queue_empty", 1'b1, 1'b0);
        end else begin
            check("branch_taken", branch_taken, exp_q.pop_front());
        end
    end

    // Registered monitor: the flop should hold the decision present at the edge
    always @(posedge clk) begin
        bit exp_r;
        exp_r = rst_n ? cur_exp : 1'b0;
        #1;
        check("branch_taken_r", branch_taken_r, exp_r);
    end

    initial begin
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        checks  = 0;
        passed  = 0;
        cur_exp = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b0;
        funct3  = 3'd0;
        rs1     = '0;
        rs2     = '0;

        #1;
        check("reset_r", branch_taken_r, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        apply(1'b1, 3'd0, 32'd5, 32'd5);
        apply(1'b1, 3'd1, 32'd5, 32'd5);
        apply(1'b1, 3'd4, -32'sd7, 32'd4);
        apply(1'b1, 3'd6, -32'sd7, 32'd4);
        apply(1'b1, 3'd5, 32'd50, 32'd30);
        apply(1'b1, 3'd5, 32'd30, 32'd30);
        apply(1'b1, 3'd7, -32'sd10, -32'sd50);
        apply(1'b0, 3'd0, 32'd0, 32'd0);
        apply(1'b1, 3'd2, 32'd1, 32'd1);
        apply(1'b1, 3'd3, 32'd9, 32'd1);
        apply(1'b1, 3'd4, 32'h8000_0000, 32'h7FFF_FFFF);
        apply(1'b1, 3'd6, 32'h8000_0000, 32'h7FFF_FFFF);
        apply(1'b1, 3'd7, 32'd30, 32'd30);
        apply(1'b1, 3'd4, 32'h7FFF_FFFF, 32'h8000_0000);

        // Async reset mid-operation: only the registered copy clears
        apply(1'b1, 3'd0, 32'd7, 32'd7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_r", branch_taken_r, 1'b0);
        check("comb_during_reset", branch_taken, 1'b1);
        apply(1'b1, 3'd1, 32'd1, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 3'd1, 32'd3, 32'd3);

        // Random vectors, biased toward equal operands and sign-boundary values
        for (int i = 0; i < 80; i++) begin
            a = $urandom();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom();
                2: begin
                    a = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 3))};
                    b = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 3))};
                end
                default: b = a ^ (32'h1 << $urandom_range(0, 31));
            endcase
            apply($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), a, b);
        end

        @(posedge clk);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 1'b0, 1'b1);
        #3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
